inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
- Instruction buffer directly downstream of ICache stage 2; sits between the I-cache output register and the decoder.
- Accepts a fetch packet of up to 8 PC/instruction pairs per cycle and stores them in program order in a circular buffer.
- Delivers up to 2 instructions per cycle to decode.
- Raises back-pressure to the fetch/cache pipeline when it cannot absorb a full packet.

Parameters:
- DEPTH, 16, number of entries; power of two, >= 8.
- PTRW, 4, log2(DEPTH); pointer width. Occupancy counter is PTRW+1 bits.

Ports:
- Clk  in  1  clock, all state on rising edge.
- Rest  in  1  asynchronous active-low reset.
- Flush  in  1  synchronous flush (branch redirect / trap); clears the queue.
- InAble  in  1  fetch packet valid.
- InPcIvt  in  256  8 PCs; lane j at [32j+31:32j], lane 0 = oldest.
- InInstIvt  in  8  lane valid mask; bit j qualifies lane j.
- InDate  in  256  8 instructions; lane j at [32j+31:32j].
- FetchStop  out  1  back-pressure; high when free entries < 8.
- DecReady  in  2  decoder accepts: 2'b00 none, 2'b01 slot0 only, 2'b11 both; 2'b10 is illegal and treated as 2'b00.
- Out0Able  out  1  slot0 valid (oldest entry).
- Out0Pc  out  32  slot0 PC.
- Out0Inst  out  32  slot0 instruction.
- Out1Able  out  1  slot1 valid (second-oldest entry).
- Out1Pc  out  32  slot1 PC.
- Out1Inst  out  32  slot1 instruction.
- QueueCount  out  PTRW+1  current occupancy, for performance counters.

Behaviour:
- Reset (Rest low, asynchronous): head=0, tail=0, count=0. Storage contents are don't-care. All outputs are 0; FetchStop=0 because free=DEPTH.
- Packet length N = number of consecutive 1s in InInstIvt starting at bit 0 (0..8).
  - Bits above the first 0 are ignored. Example: 8'b00000101 gives N=1.
- Enqueue condition: InAble & ~FetchStop & ~Flush & N>0.
  - Lane j (j<N) is written to entry (tail+j) mod DEPTH.
  - tail <= tail+N, with wrap-around through modular pointer arithmetic.
- FetchStop = (DEPTH - count) < 8. It is combinational from the registered count.
  - If InAble is high while FetchStop is high, the packet is dropped. Upstream must hold or replay it; the queue keeps no state about the dropped packet.
- Output slots:
  - Out0Able = count>=1; Out0 shows entry[head].
  - Out1Able = count>=2; Out1 shows entry[(head+1) mod DEPTH].
  - Pc/Inst of an invalid slot are driven to 0.
- Dequeue amount D:
  - D=2 when DecReady=11 and Out1Able.
  - D=1 when (DecReady=01 and Out0Able) or (DecReady=11 and only Out0Able).
  - D=0 otherwise.
  - head <= head+D (mod DEPTH).
- Same-cycle enqueue and dequeue:
  - count <= count + N_accepted - D.
  - FetchStop uses the pre-update count (conservative, no bypass).
- Latency: an entry written at edge k first appears on Out0/Out1 after edge k. There is no same-cycle pass-through from In to Out.
- Ordering: strict FIFO. Lane order is preserved, and slot0 is always older than slot1.
- Flush has priority over enqueue and dequeue:
  - head=tail=count=0 at the next edge.
  - The same-cycle packet is discarded.
  - Outputs become invalid after the edge.
- Invariants:
  - count never exceeds DEPTH and never underflows.
  - Full state count=DEPTH is legal; empty is count=0.
  - head==tail holds both when full and when empty; count disambiguates.
- No internal state machine beyond the pointers and counter. All stateful registers are on Clk with async Rest.

Test Plan:
- Reset mid-traffic: fill 8 entries, pulse Rest low between edges -> Out0Able=Out1Able=0, QueueCount=0 and FetchStop=0 immediately, before the next edge.
- Partial packet: InAble=1, InInstIvt=8'b00000111, PCs 0x1c000000/04/08, DecReady=00 -> after 1 edge QueueCount=3, Out0Pc=0x1c000000, Out1Pc=0x1c000004. Then DecReady=11 for 2 cycles -> slot PCs 0x08 then empty.
- Back-pressure at DEPTH=16: enqueue two full packets -> count=16, FetchStop=1. A third packet is dropped (count stays 16). One DecReady=11 cycle -> count=14, FetchStop stays 1 until count<=8.
- Wrap-around: preload so head=tail=12, enqueue 8 lanes with PCs P..P+28 -> entries 12..15,0..3. Dequeue 2 per cycle for 4 cycles -> PCs emerge in order P..P+28, QueueCount back to 0.
- Simultaneous enqueue/dequeue: count=6, InInstIvt=8'b00001111 with DecReady=11 -> count=8 next cycle. Mask 8'b10110011 -> N=2 accepted.
- Flush priority: count=10, Flush=1 together with InAble=1 and DecReady=11 -> next cycle count=0, Out0Able=0, and the packet is not stored.

Source files
------------

// File: rtl/inst_fetch_queue_if.sv
// Fetch-to-decode bus of the instruction fetch queue.
//
// Handshake: the fetch side offers a packet with InAble. The packet is taken on
// a rising edge only when FetchStop is low and Flush is low. When FetchStop is
// high the packet is dropped, and the fetch side must hold or replay it.
// The decode side sees OutNAble as the valid for each slot. DecReady is the
// ready signal: a slot is consumed on the edge where it is both valid and ready.
// Slot1 can only be consumed together with slot0.
interface inst_fetch_queue_if #(parameter int PTRW = 4);
   logic             Flush;
   logic             InAble;
   logic [255:0]     InPcIvt;
   logic [7:0]       InInstIvt;
   logic [255:0]     InDate;
   logic             FetchStop;
   logic [1:0]       DecReady;
   logic             Out0Able;
   logic [31:0]      Out0Pc;
   logic [31:0]      Out0Inst;
   logic             Out1Able;
   logic [31:0]      Out1Pc;
   logic [31:0]      Out1Inst;
   logic [PTRW:0]    QueueCount;

   // Fetch/decode environment side
   modport master (
      output Flush, InAble, InPcIvt, InInstIvt, InDate, DecReady,
      input  FetchStop, Out0Able, Out0Pc, Out0Inst, Out1Able, Out1Pc, Out1Inst, QueueCount
   );

   // Queue side
   modport slave (
      input  Flush, InAble, InPcIvt, InInstIvt, InDate, DecReady,
      output FetchStop, Out0Able, Out0Pc, Out0Inst, Out1Able, Out1Pc, Out1Inst, QueueCount
   );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: a circular buffer between the I-cache output and decode.
// It accepts up to 8 PC/instruction lanes per cycle and delivers up to 2 per cycle,
// in program order. head/tail are modulo-DEPTH pointers. count tells full from empty.
module inst_fetch_queue #(
   parameter int DEPTH = 16,
   parameter int PTRW  = 4
) (
   input  logic              Clk,
   input  logic              Rest,
   inst_fetch_queue_if.slave bus
);

   localparam logic [PTRW:0] CNT_DEPTH = (PTRW+1)'(DEPTH);
   localparam logic [PTRW:0] CNT_LANES = (PTRW+1)'(8);
   localparam logic [PTRW:0] CNT_ONE   = (PTRW+1)'(1);

   logic [PTRW-1:0] head_q, head_d;
   logic [PTRW-1:0] tail_q, tail_d;
   logic [PTRW:0]   count_q, count_d;

   logic [31:0]     pc_mem_q   [DEPTH];
   logic [31:0]     inst_mem_q [DEPTH];

   logic [3:0]      pkt_len;
   logic            pkt_run;
   logic            fetch_stop;
   logic            enq;
   logic [1:0]      deq_amt;
   logic            out0_able;
   logic            out1_able;
   logic [PTRW-1:0] head_p1;

   // Packet length: count the run of valid lanes starting at lane 0. Lanes after the first hole are ignored.
   always_comb begin
      pkt_len = 4'd0;
      pkt_run = 1'b1;
      for (int j = 0; j < 8; j++) begin
         if (pkt_run && bus.InInstIvt[j]) begin
            pkt_len = pkt_len + 4'd1;
         end else begin
            pkt_run = 1'b0;
         end
      end
   end

   // Back-pressure uses the registered count only. There is no credit for a dequeue in the same cycle.
   assign fetch_stop = (CNT_DEPTH - count_q) < CNT_LANES;
   assign enq        = bus.InAble & ~fetch_stop & ~bus.Flush & (pkt_len != 4'd0);

   assign out0_able  = (count_q != '0);
   assign out1_able  = (count_q > CNT_ONE);
   assign head_p1    = head_q + PTRW'(1);

   // Dequeue amount: only valid slots can be consumed, and DecReady=2'b10 is ignored.
   always_comb begin
      deq_amt = 2'd0;
      if (bus.DecReady == 2'b11) begin
         if (out1_able)      deq_amt = 2'd2;
         else if (out0_able) deq_amt = 2'd1;
      end else if (bus.DecReady == 2'b01 && out0_able) begin
         deq_amt = 2'd1;
      end
   end

   // Next pointers and occupancy. Flush overrides both enqueue and dequeue.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (bus.Flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + PTRW'(deq_amt);
         tail_d  = tail_q + (enq ? PTRW'(pkt_len) : '0);
         count_d = count_q + (enq ? (PTRW+1)'(pkt_len) : '0) - (PTRW+1)'(deq_amt);
      end
   end

   // Pointer and counter registers
   always_ff @(posedge Clk or negedge Rest) begin
      if (!Rest) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage write: lane j goes to tail+j, wrapping through the modulo pointer. Contents need no reset.
   always_ff @(posedge Clk) begin
      if (enq) begin
         for (int j = 0; j < 8; j++) begin
            if (4'(j) < pkt_len) begin
               pc_mem_q[tail_q + PTRW'(j)]   <= bus.InPcIvt[32*j +: 32];
               inst_mem_q[tail_q + PTRW'(j)] <= bus.InDate[32*j +: 32];
            end
         end
      end
   end

   assign bus.FetchStop  = fetch_stop;
   assign bus.QueueCount = count_q;
   assign bus.Out0Able   = out0_able;
   assign bus.Out0Pc     = out0_able ? pc_mem_q[head_q]    : 32'h0;
   assign bus.Out0Inst   = out0_able ? inst_mem_q[head_q]  : 32'h0;
   assign bus.Out1Able   = out1_able;
   assign bus.Out1Pc     = out1_able ? pc_mem_q[head_p1]   : 32'h0;
   assign bus.Out1Inst   = out1_able ? inst_mem_q[head_p1] : 32'h0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue. Expected values come from a FIFO model kept as a queue of {pc, inst}
// entries, and from hand-computed constants in a vector table and in the corner-case sequences.
module tb_inst_fetch_queue;

   localparam int DEPTH = 16;
   localparam int PTRW  = 4;

   logic clk;
   logic rst_n;

   inst_fetch_queue_if #(.PTRW(PTRW)) bus ();

   inst_fetch_queue #(.DEPTH(DEPTH), .PTRW(PTRW)) dut (
      .Clk  (clk),
      .Rest (rst_n),
      .bus  (bus)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [63:0] exp_q[$];

   typedef struct {
      logic        flush;
      logic        inable;
      logic [7:0]  mask;
      logic [1:0]  dr;
      logic [31:0] base;
      int          exp_count;
      logic        exp_stop;
      logic        exp_o0v;
      logic [31:0] exp_o0pc;
      logic        exp_o1v;
      logic [31:0] exp_o1pc;
   } vec_t;

   vec_t vecs[9];

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return {pc[15:0], pc[31:16]} ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model update for one edge, computed from the queue rules
   task automatic model_step(input logic flush, input logic inable, input logic [7:0] mask,
                             input logic [1:0] dr, input logic [31:0] base);
      int n;
      int d;
      bit stop;
      logic [31:0] pc;
      n = 0;
      while (n < 8 && mask[n]) n++;
      stop = (DEPTH - exp_q.size()) < 8;
      if (flush) begin
         exp_q.delete();
      end else begin
         d = 0;
         if (dr == 2'b11)      d = (exp_q.size() >= 2) ? 2 : exp_q.size();
         else if (dr == 2'b01) d = (exp_q.size() >= 1) ? 1 : 0;
         repeat (d) void'(exp_q.pop_front());
         if (inable && !stop && n > 0) begin
            for (int j = 0; j < n; j++) begin
               pc = base + 32'(4 * j);
               exp_q.push_back({pc, inst_of(pc)});
            end
         end
      end
   endtask

   // Driver: set inputs, advance the model, take one edge, then sample 1 time unit later
   task automatic apply(input logic flush, input logic inable, input logic [7:0] mask,
                        input logic [1:0] dr, input logic [31:0] base);
      logic [31:0] pc;
      bus.Flush     = flush;
      bus.InAble    = inable;
      bus.InInstIvt = mask;
      bus.DecReady  = dr;
      for (int j = 0; j < 8; j++) begin
         pc = base + 32'(4 * j);
         bus.InPcIvt[32*j +: 32] = pc;
         bus.InDate[32*j +: 32]  = inst_of(pc);
      end
      model_step(flush, inable, mask, dr, base);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      apply(1'b0, 1'b0, 8'h00, 2'b00, 32'h0);
   endtask

   task automatic check_model(input string tag);
      int sz;
      sz = exp_q.size();
      chk({tag, ".o0v"}, 64'(bus.Out0Able), 64'(sz >= 1));
      chk({tag, ".o0pc"}, 64'(bus.Out0Pc), (sz >= 1) ? 64'(exp_q[0][63:32]) : 64'h0);
      chk({tag, ".o0inst"}, 64'(bus.Out0Inst), (sz >= 1) ? 64'(exp_q[0][31:0]) : 64'h0);
      chk({tag, ".o1v"}, 64'(bus.Out1Able), 64'(sz >= 2));
      chk({tag, ".o1pc"}, 64'(bus.Out1Pc), (sz >= 2) ? 64'(exp_q[1][63:32]) : 64'h0);
      chk({tag, ".o1inst"}, 64'(bus.Out1Inst), (sz >= 2) ? 64'(exp_q[1][31:0]) : 64'h0);
      chk({tag, ".count"}, 64'(bus.QueueCount), 64'(sz));
      chk({tag, ".stop"}, 64'(bus.FetchStop), 64'((DEPTH - sz) < 8));
   endtask

   initial begin
      logic [7:0] rmask;
      logic [8:0] tmp;
      logic [31:0] p;

      // Vector table: each row is one edge, starting from an empty queue
      vecs[0] = '{1'b0, 1'b1, 8'b00000111, 2'b00, 32'h1c000000, 3, 1'b0, 1'b1, 32'h1c000000, 1'b1, 32'h1c000004};
      vecs[1] = '{1'b0, 1'b0, 8'h00,       2'b11, 32'h0,        1, 1'b0, 1'b1, 32'h1c000008, 1'b0, 32'h0};
      vecs[2] = '{1'b0, 1'b0, 8'h00,       2'b11, 32'h0,        0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
      vecs[3] = '{1'b0, 1'b1, 8'b00000101, 2'b00, 32'h20000000, 1, 1'b0, 1'b1, 32'h20000000, 1'b0, 32'h0};
      vecs[4] = '{1'b0, 1'b1, 8'hFF,       2'b10, 32'h30000000, 9, 1'b1, 1'b1, 32'h20000000, 1'b1, 32'h30000000};
      vecs[5] = '{1'b0, 1'b1, 8'hFF,       2'b00, 32'h40000000, 9, 1'b1, 1'b1, 32'h20000000, 1'b1, 32'h30000000};
      vecs[6] = '{1'b0, 1'b0, 8'h00,       2'b01, 32'h0,        8, 1'b0, 1'b1, 32'h30000000, 1'b1, 32'h30000004};
      vecs[7] = '{1'b0, 1'b1, 8'b10110011, 2'b11, 32'h50000000, 8, 1'b0, 1'b1, 32'h30000008, 1'b1, 32'h3000000c};
      vecs[8] = '{1'b1, 1'b1, 8'hFF,       2'b11, 32'h60000000, 0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};

      rst_n         = 1'b0;
      bus.Flush     = 1'b0;
      bus.InAble    = 1'b0;
      bus.InInstIvt = 8'h00;
      bus.DecReady  = 2'b00;
      bus.InPcIvt   = '0;
      bus.InDate    = '0;
      #12;
      check_model("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Table-driven vectors
      for (int i = 0; i < 9; i++) begin
         apply(vecs[i].flush, vecs[i].inable, vecs[i].mask, vecs[i].dr, vecs[i].base);
         check_model($sformatf("vec%0d", i));
         chk($sformatf("vec%0d.k_count", i), 64'(bus.QueueCount), 64'(vecs[i].exp_count));
         chk($sformatf("vec%0d.k_stop", i),  64'(bus.FetchStop),  64'(vecs[i].exp_stop));
         chk($sformatf("vec%0d.k_o0v", i),   64'(bus.Out0Able),   64'(vecs[i].exp_o0v));
         chk($sformatf("vec%0d.k_o0pc", i),  64'(bus.Out0Pc),     64'(vecs[i].exp_o0pc));
         chk($sformatf("vec%0d.k_o1v", i),   64'(bus.Out1Able),   64'(vecs[i].exp_o1v));
         chk($sformatf("vec%0d.k_o1pc", i),  64'(bus.Out1Pc),     64'(vecs[i].exp_o1pc));
      end

      // Back-pressure: fill to DEPTH, drop a packet, drain until count falls to 8
      apply(1'b1, 1'b0, 8'h00, 2'b00, 32'h0);
      apply(1'b0, 1'b1, 8'hFF, 2'b00, 32'hC0000000);
      apply(1'b0, 1'b1, 8'hFF, 2'b00, 32'hC1000000);
      chk("bp.full_count", 64'(bus.QueueCount), 64'd16);
      chk("bp.full_stop", 64'(bus.FetchStop), 64'd1);
      apply(1'b0, 1'b1, 8'hFF, 2'b00, 32'hC2000000);
      chk("bp.drop_count", 64'(bus.QueueCount), 64'd16);
      check_model("bp.drop");
      apply(1'b0, 1'b0, 8'h00, 2'b11, 32'h0);
      chk("bp.c14_count", 64'(bus.QueueCount), 64'd14);
      chk("bp.c14_stop", 64'(bus.FetchStop), 64'd1);
      apply(1'b0, 1'b0, 8'h00, 2'b11, 32'h0);
      apply(1'b0, 1'b0, 8'h00, 2'b11, 32'h0);
      chk("bp.c10_stop", 64'(bus.FetchStop), 64'd1);
      apply(1'b0, 1'b0, 8'h00, 2'b11, 32'h0);
      chk("bp.c8_count", 64'(bus.QueueCount), 64'd8);
      chk("bp.c8_stop", 64'(bus.FetchStop), 64'd0);
      check_model("bp.end");

      // Wrap-around: move head and tail to 12, then enqueue 8 lanes across the wrap
      apply(1'b1, 1'b0, 8'h00, 2'b00, 32'h0);
      apply(1'b0, 1'b1, 8'hFF, 2'b00, 32'hA0000000);
      apply(1'b0, 1'b1, 8'h0F, 2'b00, 32'hA1000000);
      repeat (6) apply(1'b0, 1'b0, 8'h00, 2'b11, 32'h0);
      chk("wrap.empty", 64'(bus.QueueCount), 64'd0);
      p = 32'hB0000000;
      apply(1'b0, 1'b1, 8'hFF, 2'b00, p);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("wrap.o0pc%0d", k), 64'(bus.Out0Pc), 64'(p + 32'(8 * k)));
         chk($sformatf("wrap.o1pc%0d", k), 64'(bus.Out1Pc), 64'(p + 32'(8 * k + 4)));
         check_model($sformatf("wrap%0d", k));
         apply(1'b0, 1'b0, 8'h00, 2'b11, 32'h0);
      end
      chk("wrap.drained", 64'(bus.QueueCount), 64'd0);

      // Simultaneous enqueue and dequeue at count 6
      apply(1'b1, 1'b0, 8'h00, 2'b00, 32'h0);
      apply(1'b0, 1'b1, 8'h3F, 2'b00, 32'hD0000000);
      apply(1'b0, 1'b1, 8'h0F, 2'b11, 32'hD1000000);
      chk("simul.count", 64'(bus.QueueCount), 64'd8);
      check_model("simul");

      // Flush priority at count 10, then confirm that the flushed packet was not stored
      apply(1'b1, 1'b0, 8'h00, 2'b00, 32'h0);
      apply(1'b0, 1'b1, 8'hFF, 2'b00, 32'hE0000000);
      apply(1'b0, 1'b1, 8'h03, 2'b00, 32'hE1000000);
      chk("flush.pre", 64'(bus.QueueCount), 64'd10);
      apply(1'b1, 1'b1, 8'hFF, 2'b11, 32'hE2000000);
      chk("flush.count", 64'(bus.QueueCount), 64'd0);
      chk("flush.o0v", 64'(bus.Out0Able), 64'd0);
      idle();
      check_model("flush.after");

      // Asynchronous reset mid-traffic, checked before the next edge
      apply(1'b0, 1'b1, 8'hFF, 2'b00, 32'hF0000000);
      chk("rst.pre", 64'(bus.QueueCount), 64'd8);
      bus.InAble = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check_model("rst.async");
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_model("rst.after");

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0: rmask = 8'($urandom_range(0, 255));
            1: rmask = 8'hFF;
            default: begin
               tmp   = (9'd1 << $urandom_range(0, 8)) - 9'd1;
               rmask = tmp[7:0];
            end
         endcase
         apply(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0), rmask,
               2'($urandom_range(0, 3)), $urandom);
         check_model($sformatf("rand%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
